// File: rtl/restoring_divider.sv
// restoring_divider: sequential restoring divider, one trial subtraction per
// clock. It computes the quotient and remainder for the ALU DIV/MOD operations
// and handshakes with the control sequencer through start and done.
//
// Ports:
//   clk, rst             rising-edge clock; asynchronous active-high reset
//   start                request, sampled only in IDLE
//   dividend, divisor    operands, captured on an accepted start
//   busy                 high while iterating (RUN)
//   done                 one-cycle pulse, results valid (FIN)
//   quotient, remainder  results, held until the next accepted start
//   div_by_zero          set with done when divisor == 0, held with results
//
// Optional feature: `define DIVIDER_SIGNED_EN for two's-complement operands.
// Magnitudes go through the unsigned engine, and the signs are fixed up on
// the way into FIN.
module restoring_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] dvd;      // dividend bits still to consume, quotient bits shifted in
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem_r;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] r_next;
  logic             last;
  logic [WIDTH-1:0] q_mag;
  logic             div_zero;

  logic [WIDTH-1:0] dvd_in;
  logic [WIDTH-1:0] dvs_in;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;

  // One restoring step: shift in the next dividend bit, then try the subtraction.
  always_comb begin
    r_shift  = {rem_r, dvd[WIDTH-1]};
    trial    = r_shift - {1'b0, dvs};
    q_bit    = ~trial[WIDTH];
    r_next   = q_bit ? trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
    q_mag    = {dvd[WIDTH-2:0], q_bit};
    last     = (cnt == CW'(WIDTH - 1));
    div_zero = (divisor == '0);
  end

`ifdef DIVIDER_SIGNED_EN
  logic neg_q;
  logic neg_r;

  always_comb begin
    dvd_in  = dividend[WIDTH-1] ? -dividend : dividend;
    dvs_in  = divisor[WIDTH-1]  ? -divisor  : divisor;
    q_final = neg_q ? -q_mag  : q_mag;
    r_final = neg_r ? -r_next : r_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && start && !div_zero) begin
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
    end
  end
`else
  always_comb begin
    dvd_in  = dividend;
    dvs_in  = divisor;
    q_final = q_mag;
    r_final = r_next;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = div_zero ? FIN : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) begin
          state_nx = FIN;
        end
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd         <= '0;
      dvs         <= '0;
      rem_r       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (div_zero) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              dvd         <= dvd_in;
              dvs         <= dvs_in;
              rem_r       <= '0;
              cnt         <= '0;
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          rem_r <= r_next;
          dvd   <= q_mag;
          cnt   <= cnt + 1'b1;
          // Results are written on the final step so that they are valid during FIN.
          if (last) begin
            quotient  <= q_final;
            remainder <= r_final;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Sequential unsigned integer divider built on the team's ripple add/subtract datapath: one trial subtraction per clock (restoring algorithm).
- Computes quotient and remainder of dividend / divisor for the ALU's DIV/MOD operations.
- Sits beside adder_subtractor in the arithmetic unit; start/done handshake toward the ALU control sequencer.

Parameters:
- WIDTH, 4, operand/quotient/remainder width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  numerator, captured on accepted start
- divisor  input  WIDTH  denominator, captured on accepted start
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse: results valid
- quotient  output  WIDTH  result quotient, held until next accepted start
- remainder  output  WIDTH  result remainder, held until next accepted start
- div_by_zero  output  1  set with done when divisor == 0, held with results

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. rst=1 forces state IDLE and busy, done, quotient, remainder, div_by_zero, plus all internal registers, to 0 immediately, regardless of clock. Reset mid-operation aborts the division with no done pulse.
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 at edge with divisor!=0: capture operands, partial remainder R=0 (WIDTH+1 bits), iteration count=0, go RUN.
  - start=1 at edge with divisor==0: go FIN with quotient=all ones, remainder=dividend, div_by_zero=1.
  - start=0: stay.
- RUN, once per cycle, MSB first:
  - R' = {R[WIDTH-1:0], next dividend bit}; T = R' - divisor (WIDTH+1-bit subtract).
  - T non-negative: R=T, quotient bit=1. Otherwise R=R' (restore), quotient bit=0.
  - After WIDTH iterations go FIN.
- FIN: done=1 for exactly one cycle; quotient and remainder valid that cycle and held afterwards; next state IDLE.
- busy=1 in RUN only. done=1 in FIN only. busy and done are never both high.
- Latency:
  - Normal: start edge at cycle 0, busy cycles 1..WIDTH, done at cycle WIDTH+1.
  - Divide-by-zero: done at cycle 1.
- Handshake:
  - start while in RUN or FIN is ignored (not queued).
  - start held high continuously launches back-to-back divisions, one per WIDTH+2 cycles.
  - Operand inputs are don't-care except at the accepted-start edge.
- div_by_zero clears on the next accepted start.
- Invariant for unsigned results: dividend = quotient*divisor + remainder, with remainder < divisor.

Optional Feature:
- Macro: DIVIDER_SIGNED_EN.
- Defined: operands and results are two's complement.
  - Magnitudes are divided by the same unsigned engine.
  - Quotient truncates toward zero and is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
  - Most-negative / -1 wraps: quotient = most-negative, remainder = 0.
  - Sign fix-up happens in FIN; latency is unchanged.
  - Divide-by-zero: quotient = all ones, remainder = dividend.
- Undefined: purely unsigned; no sign logic is synthesised.

Test Plan:
- WIDTH=4, 13/3 -> done at cycle 5, quotient=4, remainder=1, div_by_zero=0; busy high cycles 1-4.
- 15/1 -> quotient=15, remainder=0; 2/9 -> quotient=0, remainder=2. Also run all 256 operand pairs and check the division invariant.
- 7/0 -> done at cycle 1, quotient=15, remainder=7, div_by_zero=1; next 6/2 -> quotient=3, remainder=0, div_by_zero=0.
- Start 13/3, pulse start again with 9/4 at cycle 2 -> ignored; results 4 and 1 at cycle 5.
- Assert rst at cycle 3 of 13/3 -> outputs 0 immediately, no done pulse; new start 9/4 -> quotient=2, remainder=1.
- DIVIDER_SIGNED_EN: -7/2 -> quotient=4'b1101 (-3), remainder=4'b1111 (-1); -8/-1 -> quotient=4'b1000, remainder=0.
